// File: rtl/multi_clk_div_bank.sv
// multi_clk_div_bank: bank of runtime-programmable 50%-duty clock-enable dividers plus a
// free-running power-of-two chain. Defining CLKDIV_SYNC_EN adds the resync port.
module multi_clk_div_bank #(
  parameter int NUM_CH    = 4,
  parameter int DIV_W     = 12,
  parameter int RESET_DIV = 1,
  parameter int POW2_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [3:0]        wr_ch,
  input  logic [DIV_W-1:0]  wr_div,
`ifdef CLKDIV_SYNC_EN
  input  logic              resync,
`endif
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] pending,
  output logic [POW2_W-1:0] div_pow2
);

  logic [NUM_CH-1:0][DIV_W-1:0] cnt, cnt_nxt;
  logic [NUM_CH-1:0][DIV_W-1:0] active, active_nxt;
  logic [NUM_CH-1:0][DIV_W-1:0] shadow, shadow_nxt;
  logic [NUM_CH-1:0]            clk_out_nxt, tick_nxt, pending_nxt;
  logic [NUM_CH-1:0]            at_tc, disabled;
  logic [POW2_W-1:0]            pow2_cnt;
  logic                         wr_valid;
  logic                         do_resync;

`ifdef CLKDIV_SYNC_EN
  assign do_resync = resync;
`else
  assign do_resync = 1'b0;
`endif

  assign wr_valid = wr_en && (32'(wr_ch) < NUM_CH);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_tc
    assign disabled[g] = (active[g] == '0);
    assign at_tc[g]    = !disabled[g] && (cnt[g] == active[g] - DIV_W'(1));
  end

  // A write landing on a boundary cycle overrides the pending clear, so it waits for the next one.
  always_comb begin
    cnt_nxt     = cnt;
    active_nxt  = active;
    shadow_nxt  = shadow;
    pending_nxt = pending;
    clk_out_nxt = clk_out;
    tick_nxt    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (disabled[i]) begin
        cnt_nxt[i]     = '0;
        clk_out_nxt[i] = 1'b0;
        if (pending[i]) begin
          active_nxt[i]  = shadow[i];
          pending_nxt[i] = 1'b0;
        end
      end else if (at_tc[i]) begin
        cnt_nxt[i] = '0;
        if (pending[i]) begin
          active_nxt[i]  = shadow[i];
          pending_nxt[i] = 1'b0;
          if (shadow[i] != '0) begin
            clk_out_nxt[i] = ~clk_out[i];
            tick_nxt[i]    = 1'b1;
          end else begin
            clk_out_nxt[i] = 1'b0;
          end
        end else begin
          clk_out_nxt[i] = ~clk_out[i];
          tick_nxt[i]    = 1'b1;
        end
      end else begin
        cnt_nxt[i] = cnt[i] + DIV_W'(1);
      end

      if (do_resync) begin
        cnt_nxt[i]     = '0;
        clk_out_nxt[i] = 1'b0;
        tick_nxt[i]    = 1'b0;
        if (pending[i]) begin
          active_nxt[i]  = shadow[i];
          pending_nxt[i] = 1'b0;
        end
      end

      if (wr_valid && (32'(wr_ch) == i)) begin
        shadow_nxt[i]  = wr_div;
        pending_nxt[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      active   <= {NUM_CH{DIV_W'(RESET_DIV)}};
      shadow   <= {NUM_CH{DIV_W'(RESET_DIV)}};
      pending  <= '0;
      clk_out  <= '0;
      tick     <= '0;
      pow2_cnt <= '0;
    end else begin
      cnt      <= cnt_nxt;
      active   <= active_nxt;
      shadow   <= shadow_nxt;
      pending  <= pending_nxt;
      clk_out  <= clk_out_nxt;
      tick     <= tick_nxt;
      pow2_cnt <= do_resync ? '0 : pow2_cnt + POW2_W'(1);
    end
  end

  assign div_pow2 = pow2_cnt;

endmodule
